// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
//   Shared definitions for the CPU run/step/halt controller:
//   - state_t   : FSM state encoding (HALT=0, RUN=1, STEP=2)
//   - db_cycles : converts clock frequency and debounce time into clkin cycles
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  // Number of clkin cycles the step button must stay stable.
  function automatic int db_cycles(input int clk_frq, input int debounce_ms);
    return clk_frq / 1000 * debounce_ms;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
//   Synchronises an asynchronous, bouncy push-button into the clkin domain,
//   filters it with a stable-time counter and emits a one-cycle pulse on each
//   debounced 0->1 transition.
// Parameters
//   CYCLES  consecutive clkin cycles the raw level must hold before the
//           debounced level follows it
// Ports
//   clkin   in  board clock, posedge
//   reset   in  synchronous, active-high
//   btn     in  raw button level, asynchronous
//   pulse   out one-cycle pulse on a debounced rising edge
module btn_debounce #(
  parameter int CYCLES = 100
) (
  input  logic clkin,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;

  // NOTE: all state here is registered, so every assignment is non-blocking;
  // the later "pulse <= 0" default is overridden by any later assignment in
  // the same block.
  always_ff @(posedge clkin) begin
    if (reset) begin
      sync  <= '0;
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      pulse <= 1'b0;
      if (sync[1] == level) begin
        // Any sample agreeing with the debounced level restarts the wait.
        cnt <= '0;
      end else if (cnt == CW'(CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
        pulse <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl
//   Run/step/halt controller for the 8-bit CPU. Samples the divided clock in
//   the clkin domain, converts each rising edge into a tick and gates ticks
//   into a one-cycle CPU clock enable according to the run switch, the
//   debounced step button and the CPU halt request.
//   Latency from slow_clk rising to cpu_ce high is 4 clkin edges
//   (2 sync, registered edge detect, registered cpu_ce).
// Configuration
//   CYCLE_COUNT_EN  when defined, adds cycle_count (wrapping count of cpu_ce)
// Parameters
//   IN_CLK_FRQ   clkin frequency in Hz
//   DEBOUNCE_MS  step-button stable time in ms
//   CNT_W        cycle_count width (CYCLE_COUNT_EN only)
// Ports
//   clkin        in  board clock, posedge
//   reset        in  synchronous, active-high
//   slow_clk     in  divided clock, asynchronous
//   sw_run       in  run switch, asynchronous, 1 = free-run
//   btn_step     in  step push-button, asynchronous, bouncy
//   halt_req     in  CPU executed HLT, synchronous to clkin
//   cpu_ce       out one clkin-cycle enable per executed CPU cycle
//   running      out state == RUN
//   halted       out state == HALT
//   cycle_count  out count of cpu_ce pulses (CYCLE_COUNT_EN only)
module cpu_clk_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int IN_CLK_FRQ  = 1000000,
  parameter int DEBOUNCE_MS = 10
`ifdef CYCLE_COUNT_EN
  ,
  parameter int CNT_W       = 16
`endif
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             slow_clk,
  input  logic             sw_run,
  input  logic             btn_step,
  input  logic             halt_req,
  output logic             cpu_ce,
  output logic             running,
  output logic             halted
`ifdef CYCLE_COUNT_EN
  ,
  output logic [CNT_W-1:0] cycle_count
`endif
);

  localparam int DB_CYCLES = db_cycles(IN_CLK_FRQ, DEBOUNCE_MS);

  // slow_sync[1:0] is the 2-flop synchronizer, slow_sync[2] the previous
  // synchronized value used for edge detection.
  logic [2:0] slow_sync;
  logic [1:0] run_sync;
  logic       tick;
  logic       step_pulse;
  logic       step_req;
  state_t     state;

  btn_debounce #(
    .CYCLES (DB_CYCLES)
  ) u_btn_debounce (
    .clkin (clkin),
    .reset (reset),
    .btn   (btn_step),
    .pulse (step_pulse)
  );

  always_ff @(posedge clkin) begin
    if (reset) begin
      slow_sync <= '0;
      run_sync  <= '0;
      tick      <= 1'b0;
    end else begin
      slow_sync <= {slow_sync[1:0], slow_clk};
      run_sync  <= {run_sync[0], sw_run};
      tick      <= slow_sync[1] & ~slow_sync[2];
    end
  end

  // running/halted are updated together with state so they always decode the
  // current state without an extra cycle of lag.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state    <= ST_HALT;
      cpu_ce   <= 1'b0;
      running  <= 1'b0;
      halted   <= 1'b1;
      step_req <= 1'b0;
    end else begin
      cpu_ce   <= 1'b0;
      // Presses in any state are latched; at most one stays pending.
      step_req <= step_req | step_pulse;
      case (state)
        ST_HALT: begin
          if (run_sync[1] && !halt_req) begin
            state   <= ST_RUN;
            running <= 1'b1;
            halted  <= 1'b0;
          end else if (step_req) begin
            state    <= ST_STEP;
            halted   <= 1'b0;
            step_req <= step_pulse;
          end
        end
        ST_RUN: begin
          // Leaving RUN takes priority over a coincident tick.
          if (!run_sync[1] || halt_req) begin
            state   <= ST_HALT;
            running <= 1'b0;
            halted  <= 1'b1;
          end else if (tick) begin
            cpu_ce <= 1'b1;
          end
        end
        ST_STEP: begin
          if (tick) begin
            cpu_ce <= 1'b1;
            state  <= ST_HALT;
            halted <= 1'b1;
          end
        end
        default: begin
          state   <= ST_HALT;
          running <= 1'b0;
          halted  <= 1'b1;
        end
      endcase
    end
  end

`ifdef CYCLE_COUNT_EN
  always_ff @(posedge clkin) begin
    if (reset) begin
      cycle_count <= '0;
    end else if (cpu_ce) begin
      cycle_count <= cycle_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// tb_cpu_clk_ctrl
//   Directed self-checking bench for cpu_clk_ctrl with IN_CLK_FRQ=100000 and
//   DEBOUNCE_MS=1 (100-cycle debounce). slow_clk is generated by the bench
//   with a 40-clkin period, changing on the clkin falling edge; outputs are
//   sampled on the falling edge. With CYCLE_COUNT_EN defined the counter is
//   built 4 bits wide and its wrap is exercised.
module tb_cpu_clk_ctrl;

  logic clkin    = 1'b0;
  logic reset    = 1'b1;
  logic slow_clk = 1'b0;
  logic sw_run   = 1'b0;
  logic btn_step = 1'b0;
  logic halt_req = 1'b0;
  logic cpu_ce;
  logic running;
  logic halted;
`ifdef CYCLE_COUNT_EN
  logic [3:0] cycle_count;
`endif

  int total      = 0;
  int bad        = 0;
  int ph         = 0;
  int since_rise = 100;
  bit slow_en    = 1'b1;

  always #5 clkin = ~clkin;

  cpu_clk_ctrl #(
    .IN_CLK_FRQ  (100000),
    .DEBOUNCE_MS (1)
`ifdef CYCLE_COUNT_EN
    ,
    .CNT_W       (4)
`endif
  ) dut (
    .clkin       (clkin),
    .reset       (reset),
    .slow_clk    (slow_clk),
    .sw_run      (sw_run),
    .btn_step    (btn_step),
    .halt_req    (halt_req),
    .cpu_ce      (cpu_ce),
    .running     (running),
    .halted      (halted)
`ifdef CYCLE_COUNT_EN
    ,
    .cycle_count (cycle_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge (one posedge has passed), then move the
  // slow clock generator. since_rise counts posedges since the last rise.
  task automatic cyc();
    @(negedge clkin);
    since_rise++;
    if (slow_en) begin
      ph++;
      if (ph == 20) begin
        ph       = 0;
        slow_clk = ~slow_clk;
        if (slow_clk) since_rise = 0;
      end
    end
  endtask

  initial begin
    int  n;
    int  first_ce;
    bit  prev_ce;
    bit  seen_ce;
    bit  seen_run;
    bit  seen_step;
    bit  found;

    // 1: reset held 5 cycles with slow_clk toggling and sw_run low
    ph = 15;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("t1_rst_halted", halted, 1);
      check("t1_rst_running", running, 0);
      check("t1_rst_ce", cpu_ce, 0);
    end
    reset   = 1'b0;
    seen_ce = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (cpu_ce) seen_ce = 1'b1;
    end
    check("t1_idle_no_ce", seen_ce, 0);
    check("t1_idle_halted", halted, 1);

    // 2: free run for 400 cycles; rises at cycles 20,60,...,380
    ph         = 0;
    slow_clk   = 1'b0;
    since_rise = 100;
    sw_run     = 1'b1;
    repeat (3) cyc();
    check("t2_running", running, 1);
    check("t2_not_halted", halted, 0);
    n       = 0;
    prev_ce = 1'b0;
    for (int i = 3; i < 400; i++) begin
      cyc();
      if (cpu_ce) begin
        n++;
        check("t2_ce_latency", since_rise, 4);
        check("t2_ce_width", prev_ce, 0);
      end
      prev_ce = cpu_ce;
    end
    check("t2_ce_count", n, 10);
    sw_run = 1'b0;
    repeat (5) cyc();
    check("t2_halted_after_stop", halted, 1);

    // 3: bouncing step button, then stable press -> exactly one cpu_ce
    n         = 0;
    first_ce  = -1;
    seen_step = 1'b0;
    for (int i = 0; i < 330; i++) begin
      if (i < 60 && (i % 7) == 0) btn_step = ~btn_step;
      if (i == 60)  btn_step = 1'b1;
      if (i == 210) btn_step = 1'b0;
      cyc();
      if (cpu_ce) begin
        n++;
        if (first_ce < 0) first_ce = i;
      end
      if (!running && !halted) seen_step = 1'b1;
    end
    check("t3_one_step_ce", n, 1);
    check("t3_step_state_seen", seen_step, 1);
    check("t3_ce_after_debounce", first_ce > 150, 1);
    check("t3_halted_after_step", halted, 1);
    check("t3_running_after_step", running, 0);

    // 4: halt_req on the tick edge drops the tick
    sw_run   = 1'b1;
    halt_req = 1'b0;
    found    = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (running && since_rise == 3) begin
        found = 1'b1;
        break;
      end
    end
    check("t4_run_before_tick", found, 1);
    halt_req = 1'b1;
    cyc();
    check("t4_tick_edge", since_rise, 4);
    check("t4_no_ce_on_halt", cpu_ce, 0);
    check("t4_halted_next", halted, 1);
    seen_ce  = 1'b0;
    seen_run = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (cpu_ce)  seen_ce  = 1'b1;
      if (running) seen_run = 1'b1;
    end
    check("t4_hold_no_run", seen_run, 0);
    check("t4_hold_no_ce", seen_ce, 0);
    check("t4_hold_halted", halted, 1);

    // 5: reset during STEP before any tick
    sw_run   = 1'b0;
    halt_req = 1'b0;
    repeat (5) cyc();
    slow_en  = 1'b0;
    btn_step = 1'b1;
    found    = 1'b0;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (!running && !halted) begin
        found = 1'b1;
        break;
      end
    end
    check("t5_entered_step", found, 1);
    btn_step = 1'b0;
    cyc();
    check("t5_step_waits", halted, 0);
    check("t5_step_no_ce", cpu_ce, 0);
    reset = 1'b1;
    repeat (2) begin
      cyc();
      check("t5_reset_no_ce", cpu_ce, 0);
    end
    reset = 1'b0;
    cyc();
    check("t5_halted_after_reset", halted, 1);
    slow_en = 1'b1;
    seen_ce = 1'b0;
    for (int i = 0; i < 150; i++) begin
      cyc();
      if (cpu_ce) seen_ce = 1'b1;
    end
    check("t5_step_discarded", seen_ce, 0);
    check("t5_still_halted", halted, 1);

`ifdef CYCLE_COUNT_EN
    // 6: 4-bit counter wraps after 16 pulses, 18 pulses leave it at 2
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    cyc();
    check("t6_count_reset", cycle_count, 0);
    ph         = 0;
    slow_clk   = 1'b0;
    since_rise = 100;
    sw_run     = 1'b1;
    n          = 0;
    found      = 1'b0;
    for (int i = 0; i < 900; i++) begin
      cyc();
      if (found) begin
        check("t6_wrap_to_zero", cycle_count, 0);
        found = 1'b0;
      end
      if (cpu_ce) begin
        n++;
        if (n == 16) found = 1'b1;
      end
      if (n == 18) break;
    end
    sw_run = 1'b0;
    repeat (5) cyc();
    check("t6_pulses", n, 18);
    check("t6_count_final", cycle_count, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
